// File: rtl/letter_reader.sv
// Column-serial recogniser for the letters I, L and T on a WIDTH-row display.
// Moore FSM with registered letter flags and a saturating letter counter.
module letter_reader #(
  parameter int WIDTH   = 3,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               valid,
  input  logic [WIDTH-1:0]   bits,
  output logic               I,
  output logic               L,
  output logic               T,
  output logic [COUNT_W-1:0] letter_count
);

  localparam logic [3:0] GARBAGE = 4'd0;
  localparam logic [3:0] BLANK   = 4'd1;
  localparam logic [3:0] S_F     = 4'd2;
  localparam logic [3:0] S_FB    = 4'd3;
  localparam logic [3:0] S_T     = 4'd4;
  localparam logic [3:0] S_TF    = 4'd5;
  localparam logic [3:0] S_TFT   = 4'd6;
  localparam logic [3:0] DONE_I  = 4'd7;
  localparam logic [3:0] DONE_L  = 4'd8;
  localparam logic [3:0] DONE_T  = 4'd9;

  localparam logic [WIDTH-1:0]   COL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   COL_FULL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   COL_TOP  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   COL_BOT  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1'b1);

  logic [3:0]         state_r;
  logic [3:0]         next_s;
  logic               is_z_s;
  logic               is_f_s;
  logic               is_tp_s;
  logic               is_bt_s;
  logic               enter_done_s;
  logic               flag_i_r;
  logic               flag_l_r;
  logic               flag_t_r;
  logic [COUNT_W-1:0] letter_count_r;

  // Column class decode
  always_comb begin
    is_z_s  = (bits == COL_ZERO);
    is_f_s  = (bits == COL_FULL);
    is_tp_s = (bits == COL_TOP);
    is_bt_s = (bits == COL_BOT);
  end

  // Next-state logic; DONE states behave as an opening blank
  always_comb begin
    next_s = state_r;
    if (valid) begin
      case (state_r)
        GARBAGE: begin
          if (is_z_s) next_s = BLANK;
          else        next_s = GARBAGE;
        end
        BLANK, DONE_I, DONE_L, DONE_T: begin
          if (is_z_s)       next_s = BLANK;
          else if (is_f_s)  next_s = S_F;
          else if (is_tp_s) next_s = S_T;
          else              next_s = GARBAGE;
        end
        S_F: begin
          if (is_z_s)       next_s = DONE_I;
          else if (is_bt_s) next_s = S_FB;
          else              next_s = GARBAGE;
        end
        S_FB: begin
          if (is_z_s) next_s = DONE_L;
          else        next_s = GARBAGE;
        end
        S_T: begin
          if (is_f_s) next_s = S_TF;
          else        next_s = GARBAGE;
        end
        S_TF: begin
          if (is_tp_s) next_s = S_TFT;
          else         next_s = GARBAGE;
        end
        S_TFT: begin
          if (is_z_s) next_s = DONE_T;
          else        next_s = GARBAGE;
        end
        default: next_s = GARBAGE;
      endcase
    end else begin
      next_s = state_r;
    end
  end

  // Only a real transition into a DONE state counts a letter
  always_comb begin
    if (valid) begin
      enter_done_s = (next_s == DONE_I) || (next_s == DONE_L) || (next_s == DONE_T);
    end else begin
      enter_done_s = 1'b0;
    end
  end

  // State, flag and counter registers; flags track the state being entered
  always_ff @(posedge clk) begin
    if (restart) begin
      state_r        <= GARBAGE;
      flag_i_r       <= 1'b0;
      flag_l_r       <= 1'b0;
      flag_t_r       <= 1'b0;
      letter_count_r <= {COUNT_W{1'b0}};
    end else if (valid) begin
      state_r  <= next_s;
      flag_i_r <= (next_s == DONE_I);
      flag_l_r <= (next_s == DONE_L);
      flag_t_r <= (next_s == DONE_T);
      if (enter_done_s && (letter_count_r != CNT_MAX)) begin
        letter_count_r <= letter_count_r + CNT_ONE;
      end else begin
        letter_count_r <= letter_count_r;
      end
    end else begin
      state_r        <= state_r;
      flag_i_r       <= flag_i_r;
      flag_l_r       <= flag_l_r;
      flag_t_r       <= flag_t_r;
      letter_count_r <= letter_count_r;
    end
  end

  assign I            = flag_i_r;
  assign L            = flag_l_r;
  assign T            = flag_t_r;
  assign letter_count = letter_count_r;

endmodule

// File: tb/tb_letter_reader.sv
// Directed bench: three letter_reader instances (3x4, 3x2 saturating, 5x4) fed the same
// symbolic column stream and checked against hand-computed flags and letter counts.
module tb_letter_reader;

  localparam int CZ  = 0;  // blank
  localparam int CF  = 1;  // full
  localparam int CTP = 2;  // top only
  localparam int CBT = 3;  // bottom only
  localparam int CX  = 4;  // other
  localparam int CN  = 5;  // noise driven while valid is low

  logic       clk;
  logic       restart;
  logic       valid;
  logic [2:0] bits3;
  logic [4:0] bits5;

  logic       a_i, a_l, a_t;
  logic [3:0] a_cnt;
  logic       b_i, b_l, b_t;
  logic [1:0] b_cnt;
  logic       c_i, c_l, c_t;
  logic [3:0] c_cnt;

  int checks;
  int errors;
  int n;

  letter_reader #(.WIDTH(3), .COUNT_W(4)) dut_a (
    .clk(clk), .restart(restart), .valid(valid), .bits(bits3),
    .I(a_i), .L(a_l), .T(a_t), .letter_count(a_cnt));

  letter_reader #(.WIDTH(3), .COUNT_W(2)) dut_b (
    .clk(clk), .restart(restart), .valid(valid), .bits(bits3),
    .I(b_i), .L(b_l), .T(b_t), .letter_count(b_cnt));

  letter_reader #(.WIDTH(5), .COUNT_W(4)) dut_c (
    .clk(clk), .restart(restart), .valid(valid), .bits(bits5),
    .I(c_i), .L(c_l), .T(c_t), .letter_count(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one column on the falling edge and let the rising edge sample it
  task automatic step(input logic rs, input logic vd, input int c);
    @(negedge clk);
    restart = rs;
    valid   = vd;
    case (c)
      CZ:  begin bits3 = 3'b000; bits5 = 5'b00000; end
      CF:  begin bits3 = 3'b111; bits5 = 5'b11111; end
      CTP: begin bits3 = 3'b100; bits5 = 5'b10000; end
      CBT: begin bits3 = 3'b001; bits5 = 5'b00001; end
      CX:  begin bits3 = 3'b010; bits5 = 5'b00100; end
      default: begin bits3 = 3'b101; bits5 = 5'b10101; end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Compare all three instances; flags packed as {I,L,T}, cnt is letters since restart
  task automatic expect_all(input string tag, input logic [2:0] flags, input int cnt);
    int bsat;
    bsat = (cnt > 3) ? 3 : cnt;
    check({tag, ".a_flags"}, {29'd0, a_i, a_l, a_t}, {29'd0, flags});
    check({tag, ".a_cnt"},   {28'd0, a_cnt}, cnt);
    check({tag, ".b_flags"}, {29'd0, b_i, b_l, b_t}, {29'd0, flags});
    check({tag, ".b_cnt"},   {30'd0, b_cnt}, bsat);
    check({tag, ".c_flags"}, {29'd0, c_i, c_l, c_t}, {29'd0, flags});
    check({tag, ".c_cnt"},   {28'd0, c_cnt}, cnt);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    n       = 0;
    restart = 1'b1;
    valid   = 1'b0;
    bits3   = 3'b000;
    bits5   = 5'b00000;

    // Blank sampled under restart must not open a letter
    step(1'b1, 1'b1, CF);  expect_all("rst_f", 3'b000, 0);
    step(1'b1, 1'b1, CZ);  expect_all("rst_z", 3'b000, 0);
    step(1'b0, 1'b1, CF);  expect_all("norm_f", 3'b000, 0);
    step(1'b0, 1'b1, CZ);  expect_all("norm_z", 3'b000, 0);

    // I = Z F Z, flag lasts one valid cycle
    step(1'b0, 1'b1, CZ);  expect_all("i_open", 3'b000, 0);
    step(1'b0, 1'b1, CF);  expect_all("i_full", 3'b000, 0);
    step(1'b0, 1'b1, CZ);  n = 1; expect_all("i_done", 3'b100, n);
    step(1'b0, 1'b1, CZ);  expect_all("i_drop", 3'b000, n);

    // L then T after a restart
    step(1'b1, 1'b1, CZ);  n = 0; expect_all("rst2", 3'b000, n);
    step(1'b0, 1'b1, CZ);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CBT); expect_all("l_fb", 3'b000, n);
    step(1'b0, 1'b1, CZ);  n = 1; expect_all("l_done", 3'b010, n);
    step(1'b0, 1'b1, CZ);  expect_all("l_drop", 3'b000, n);
    step(1'b0, 1'b1, CTP);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CTP); expect_all("t_tft", 3'b000, n);
    step(1'b0, 1'b1, CZ);  n = 2; expect_all("t_done", 3'b001, n);

    // Double full: no letter, then a clean I
    step(1'b0, 1'b1, CZ);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CF);  expect_all("ff_garb", 3'b000, n);
    step(1'b0, 1'b1, CZ);  expect_all("ff_z", 3'b000, n);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CZ);  n = 3; expect_all("ff_i", 3'b100, n);

    // X after full: no letter, then a clean I
    step(1'b0, 1'b1, CZ);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CX);
    step(1'b0, 1'b1, CZ);  expect_all("fx_z", 3'b000, n);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CZ);  n = 4; expect_all("fx_i", 3'b100, n);

    // Extra bottom column: no L
    step(1'b0, 1'b1, CZ);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CBT);
    step(1'b0, 1'b1, CBT);
    step(1'b0, 1'b1, CZ);  expect_all("fbb_z", 3'b000, n);

    // Gapped I with valid low and noisy bits between columns
    step(1'b0, 1'b1, CZ);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, CN);
    step(1'b0, 1'b1, CF);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, CN); expect_all("gap_sf", 3'b000, n);
    end
    step(1'b0, 1'b1, CZ);  n = 5; expect_all("gap_i", 3'b100, n);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, CN); expect_all("gap_hold", 3'b100, n);
    end

    // Back-to-back I's; shared blanks, COUNT_W=2 instance saturates at 3
    step(1'b1, 1'b1, CZ);  n = 0; expect_all("rst3", 3'b000, n);
    step(1'b0, 1'b1, CZ);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, CF); expect_all("b2b_f", 3'b000, n);
      step(1'b0, 1'b1, CZ); n++; expect_all("b2b_i", 3'b100, n);
    end

    // Restart inside a T abandons it; no T without a fresh opening blank
    step(1'b0, 1'b1, CTP);
    step(1'b0, 1'b1, CF);
    step(1'b1, 1'b1, CTP); n = 0; expect_all("rst_tf", 3'b000, n);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CTP);
    step(1'b0, 1'b1, CZ);  expect_all("post_rst", 3'b000, n);
    step(1'b0, 1'b1, CTP);
    step(1'b0, 1'b1, CF);
    step(1'b0, 1'b1, CTP);
    step(1'b0, 1'b1, CZ);  n = 1; expect_all("post_t", 3'b001, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/letter_reader.md
Name: letter_reader

Overview:
- Parametrised successor to the single-letter column reader.
- Samples one column of a WIDTH-row display per valid clock and recognises the letters I, L and T.
- Letters are framed by blank columns, and a closing blank doubles as the next letter's opening blank.
- Keeps a saturating count of recognised letters for the word-level logic downstream.

Parameters:
- WIDTH, 3: rows per column (bits per sample); must be >= 2.
- COUNT_W, 4: width of letter_count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- restart  input  1  synchronous, active-high reset.
- valid  input  1  column strobe; bits is sampled only when high.
- bits  input  WIDTH  current column; bit WIDTH-1 = top row, bit 0 = bottom row.
- I  output  1  high while the FSM is in DONE_I.
- L  output  1  high while the FSM is in DONE_L.
- T  output  1  high while the FSM is in DONE_T.
- letter_count  output  COUNT_W  number of letters recognised since restart; saturates.

Behaviour:
- One clock, clk. restart is synchronous and active-high.
- Column classes, decoded combinationally from bits:
  - Z (blank) = all zeros.
  - F (full) = all ones.
  - Tp (top) = only bit WIDTH-1 set.
  - Bt (bottom) = only bit 0 set.
  - X = anything else.
- Letter shapes, as column sequences:
  - I = Z F Z.
  - L = Z F Bt Z.
  - T = Z Tp F Tp Z.
- Reset: when restart=1 at an edge, state <= GARBAGE, letter_count <= 0, I/L/T = 0.
  - restart has priority over valid.
  - A blank sampled while restart=1 does not open a letter.
- valid=0: state and letter_count hold; outputs hold, since they are Moore.
- FSM is Moore. Outputs are decoded from registered state only, so there is no combinational path from bits.
- States: GARBAGE, BLANK, S_F, S_FB, S_T, S_TF, S_TFT, DONE_I, DONE_L, DONE_T.
- Transitions, evaluated only when valid=1 and restart=0:
  - GARBAGE: Z->BLANK; else stay.
  - BLANK, DONE_I, DONE_L, DONE_T (all act as an opening blank): Z->BLANK; F->S_F; Tp->S_T; else GARBAGE.
  - S_F: Z->DONE_I; Bt->S_FB; else GARBAGE.
  - S_FB: Z->DONE_L; else GARBAGE.
  - S_T: F->S_TF; else GARBAGE.
  - S_TF: Tp->S_TFT; else GARBAGE.
  - S_TFT: Z->DONE_T; else GARBAGE.
- Output latency: the letter flag rises on the edge that samples the closing Z. It stays high until the next valid sample moves the FSM out of the DONE state.
- letter_count:
  - Increments by 1 on every edge that enters a DONE_* state.
  - Holds at 2^COUNT_W-1 once reached; no wrap.
  - A DONE state held by valid=0 counts once only.
- Back-to-back letters: Z F Z F Z produces I twice. The middle Z closes the first I and opens the second.
- Extra columns produce no letter:
  - Z F F Z -> GARBAGE, no I.
  - Z F Bt Bt Z -> no L.
- restart mid-letter abandons the partial letter. The next letter still needs a fresh opening Z sampled with restart=0.
- Unused or illegal state encodings must return to GARBAGE on the next valid edge.

Test Plan:
- restart=1, valid=1, bits 111 then 000, then restart=0 and bits 111, 000 -> I stays 0 throughout and letter_count=0 (no opening blank sampled with restart=0).
- restart=0, valid=1, bits 000, 111, 000 -> I=1 for exactly one cycle after the third edge; letter_count 0->1; L=T=0.
- bits 000, 111, 001, 000 -> L pulses once, letter_count=1. Then bits 000, 100, 111, 100, 000 -> T pulses once, letter_count=2.
- Each of these sequences -> no flag and letter_count unchanged; after each, a following 111, 000 yields a valid I:
  - bits 000, 111, 111, 000 (double full).
  - bits 000, 111, 010, 000 (X after full).
- valid toggled low for 3 cycles between every column of an I (bits changing to 101 while valid=0) -> I is recognised exactly as with valid held high. While I is held high for 3 invalid cycles, letter_count increments once.
- COUNT_W=2, seven back-to-back I's -> letter_count 1, 2, 3, 3, 3, 3, 3.
- Repeat the above with WIDTH=5, using 11111, 10000 and 00001 -> identical flag timing.
- restart asserted during S_TF -> next cycle T=0 and letter_count=0.
